pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 2, cycles to drain after halt reaches EX/MEM (legal range 1..15).
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 ihit  in  1  instruction fetch completes this cycle.
REQ-005 dhit  in  1  data access completes this cycle.
REQ-006 dmemREN_EX_MEM, dmemWEN_EX_MEM  in  1 each  data access pending in MEM stage.
REQ-007 halt_EX_MEM  in  1  halt instruction in MEM stage.
REQ-008 branch_taken_EX  in  1  branch/jump redirect resolved in EX.
REQ-009 memread_ID_EX  in  1; Rt_ID_EX  in  5; Rs_IF_ID, Rt_IF_ID  in  5 each  load-use operands.
REQ-010 pc_en  out  1  PC update enable.
REQ-011 imemREN  out  1  instruction fetch request.
REQ-012 enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each.
REQ-013 flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each.
REQ-014 halt  out  1  core halted, sticky.
REQ-015 stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-016 The FSM SHALL have states RUN, DRAIN, HALTED; outputs are Mealy from state and inputs.
REQ-017 RUN priority, highest first: halt, dmem stall, branch flush, load-use, imem miss, normal.
REQ-018 Halt: halt_EX_MEM=1 and no dmem stall → enable_MEM_WB=1, flush IF_ID/ID_EX/EX_MEM, pc_en=0, next state DRAIN, drain counter loads DRAIN_CYCLES-1.
REQ-019 Dmem stall (dmem request & !dhit): all enables 0, all flushes 0, pc_en=0 (full freeze, MEM/WB held).
REQ-020 Branch flush: flush_IF_ID=1, flush_ID_EX=1, other enables 1, pc_en=1 regardless of ihit.
REQ-021 Load-use: memread_ID_EX & Rt_ID_EX≠0 & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID): enable_IF_ID=0, pc_en=0, flush_ID_EX=1, EX_MEM/MEM_WB enabled; one bubble per match.
REQ-022 Imem miss (!ihit): pc_en=0, flush_IF_ID=1, other enables 1.
REQ-023 Normal: all enables 1, all flushes 0, pc_en=1.
REQ-024 imemREN SHALL be 1 in RUN, 0 in DRAIN and HALTED.
REQ-025 DRAIN: pc_en=0, flush IF_ID/ID_EX/EX_MEM=1, enable_MEM_WB=1; counter decrements; at 0 next state HALTED; inputs ignored.
REQ-026 HALTED: all enables 0, all flushes 0, pc_en=0, halt=1 until RST.
REQ-027 Flush SHALL never be asserted together with a 0 enable on the same register except in DRAIN for IF_ID/ID_EX/EX_MEM.

Reset
REQ-028 While RST=1: state RUN, drain counter 0, halt=0, counters 0, pc_en=0, imemREN=0, all enables 0, all flushes 1.
REQ-029 RST asserted mid-DRAIN or in HALTED SHALL return to RUN on the next edge with no residual count.

Configuration
REQ-030 Macro PIPE_PERF_EN defined: stall_cnt increments each RUN cycle with pc_en=0; flush_cnt increments per branch-flush cycle; both saturate at 32'hFFFFFFFF.
REQ-031 PIPE_PERF_EN undefined: stall_cnt and flush_cnt ports present, tied to 0, no counter flops.

Structure
REQ-032 State enum pipe_seq_state_t (RUN, DRAIN, HALTED) SHALL live in a shared package pipeline_seq_pkg with DRAIN_CNT_W=4.
REQ-033 Load-use comparison SHALL be a combinational sub-module load_use_detect.

Verification
REQ-034 Reset: RST=1 two cycles → all flushes 1, enables 0, halt=0; release with ihit=1 → normal, pc_en=1.
REQ-035 Load-use: memread_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5 → enable_IF_ID=0, pc_en=0, flush_ID_EX=1 for exactly one cycle.
REQ-036 Dmem stall: dmemREN_EX_MEM=1, dhit=0 for 3 cycles plus branch_taken_EX=1 → full freeze 3 cycles, branch flush on dhit cycle.
REQ-037 Halt: halt_EX_MEM=1, DRAIN_CYCLES=2 → DRAIN 2 cycles, halt=1 on third edge, stays 1 with random inputs.
REQ-038 Perf (PIPE_PERF_EN): 4 miss cycles and 2 branch flushes → stall_cnt=4, flush_cnt=2; without macro both read 0.

Source files
------------

// File: rtl/pipeline_seq_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, drain counter
// width and a saturating increment used by the optional performance counters.
package pipeline_seq_pkg;

  localparam int unsigned DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pipe_seq_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Load-use hazard detection: a load in ID/EX whose destination feeds either
// source operand of the instruction in IF/ID. Register 0 never creates a hazard.
module load_use_detect (
  input  logic       memread_ID_EX,
  input  logic [4:0] Rt_ID_EX,
  input  logic [4:0] Rs_IF_ID,
  input  logic [4:0] Rt_IF_ID,
  output logic       load_use
);

  always_comb begin
    load_use = memread_ID_EX & (Rt_ID_EX != 5'd0) &
               ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard/halt sequencer: RUN/DRAIN/HALTED FSM with Mealy stage controls.
// Optional stall/flush performance counters are built when PIPE_PERF_EN is defined.
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN_EX_MEM,
  input  logic        dmemWEN_EX_MEM,
  input  logic        halt_EX_MEM,
  input  logic        branch_taken_EX,
  input  logic        memread_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  input  logic [4:0]  Rs_IF_ID,
  input  logic [4:0]  Rt_IF_ID,
  output logic        pc_en,
  output logic        imemREN,
  output logic        enable_IF_ID,
  output logic        enable_ID_EX,
  output logic        enable_EX_MEM,
  output logic        enable_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
  output logic        halt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  pipe_seq_state_t        state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   load_use;
  logic                   dmem_stall;
  logic                   halt_go;
  // Bit order for both vectors: [3]=IF_ID, [2]=ID_EX, [1]=EX_MEM, [0]=MEM_WB
  logic [3:0]             en;
  logic [3:0]             fl;

  load_use_detect u_load_use_detect (
    .memread_ID_EX (memread_ID_EX),
    .Rt_ID_EX      (Rt_ID_EX),
    .Rs_IF_ID      (Rs_IF_ID),
    .Rt_IF_ID      (Rt_IF_ID),
    .load_use      (load_use)
  );

  always_comb begin
    dmem_stall = (dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit;
    halt_go    = (state == RUN) & halt_EX_MEM & ~dmem_stall;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        HALTED: state <= HALTED;
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_en   = 1'b0;
    imemREN = 1'b0;
    en      = '0;
    fl      = '0;
    halt    = 1'b0;
    if (RST) begin
      fl = '1;
    end else begin
      case (state)
        RUN: begin
          imemREN = 1'b1;
          en      = '1;
          if (halt_go) begin
            fl = 4'b1110;
          end else if (dmem_stall) begin
            en = '0;
          end else if (branch_taken_EX) begin
            pc_en = 1'b1;
            fl    = 4'b1100;
          end else if (load_use) begin
            en = 4'b0111;
            fl = 4'b0100;
          end else if (!ihit) begin
            fl = 4'b1000;
          end else begin
            pc_en = 1'b1;
          end
        end
        DRAIN: begin
          en = 4'b0001;
          fl = 4'b1110;
        end
        HALTED: halt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = en;
    {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB}     = fl;
  end

`ifdef PIPE_PERF_EN
  logic        stall_evt;
  logic        flush_evt;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_comb begin
    stall_evt = ~RST & (state == RUN) & ~pc_en;
    flush_evt = ~RST & (state == RUN) & ~halt_go & ~dmem_stall & branch_taken_EX;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt) stall_q <= sat_inc(stall_q);
      if (flush_evt) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_pipeline_sequencer;

  localparam int unsigned DC = 2;

  // Expected control words: {pc_en, imemREN, en IF/ID/EX/WB, fl IF/ID/EX/WB, halt}
  localparam logic [10:0] V_RESET  = 11'b00_0000_1111_0;
  localparam logic [10:0] V_NORMAL = 11'b11_1111_0000_0;
  localparam logic [10:0] V_MISS   = 11'b01_1111_1000_0;
  localparam logic [10:0] V_LU     = 11'b01_0111_0100_0;
  localparam logic [10:0] V_BR     = 11'b11_1111_1100_0;
  localparam logic [10:0] V_FREEZE = 11'b01_0000_0000_0;
  localparam logic [10:0] V_HALTGO = 11'b01_1111_1110_0;
  localparam logic [10:0] V_DRAIN  = 11'b00_0001_1110_0;
  localparam logic [10:0] V_HALTED = 11'b00_0000_0000_1;

  localparam int C_RESET = 0, C_NORMAL = 1, C_MISS = 2, C_LU = 3, C_BR = 4,
                 C_FREEZE = 5, C_HALTGO = 6, C_DRAIN = 7, C_HALTED = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, halt_EX_MEM;
  logic        branch_taken_EX, memread_ID_EX;
  logic [4:0]  Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic        pc_en, imemREN, halt;
  logic        enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic [31:0] stall_cnt, flush_cnt;
  logic [10:0] ctrl;

  always #5 CLK = ~CLK;

  pipeline_sequencer #(.DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
    .halt_EX_MEM(halt_EX_MEM), .branch_taken_EX(branch_taken_EX),
    .memread_ID_EX(memread_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .pc_en(pc_en), .imemREN(imemREN),
    .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
    .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_en, imemREN, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                 flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halt};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline mode plus number of drain cycles still owed.
  int          m_mode  = M_RUN;
  int          m_left  = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  bit          m_valid = 1'b0;

  function automatic int classify();
    bit dstall, lu;
    if (RST) return C_RESET;
    if (m_mode == M_DRAIN)  return C_DRAIN;
    if (m_mode == M_HALTED) return C_HALTED;
    dstall = (dmemREN_EX_MEM || dmemWEN_EX_MEM) && !dhit;
    lu = memread_ID_EX && (Rt_ID_EX != 0) && (Rt_ID_EX == Rs_IF_ID || Rt_ID_EX == Rt_IF_ID);
    if (halt_EX_MEM && !dstall) return C_HALTGO;
    if (dstall)                 return C_FREEZE;
    if (branch_taken_EX)        return C_BR;
    if (lu)                     return C_LU;
    if (!ihit)                  return C_MISS;
    return C_NORMAL;
  endfunction

  function automatic logic [10:0] vec(input int c);
    case (c)
      C_RESET:  return V_RESET;
      C_NORMAL: return V_NORMAL;
      C_MISS:   return V_MISS;
      C_LU:     return V_LU;
      C_BR:     return V_BR;
      C_FREEZE: return V_FREEZE;
      C_HALTGO: return V_HALTGO;
      C_DRAIN:  return V_DRAIN;
      default:  return V_HALTED;
    endcase
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef PIPE_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush();
`ifdef PIPE_PERF_EN
    return m_flush;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge CLK) begin
    int c;
    c = classify();
    if (RST) begin
      m_mode = M_RUN; m_left = 0; m_stall = '0; m_flush = '0; m_valid = 1'b1;
    end else begin
      if (c == C_MISS || c == C_LU || c == C_FREEZE || c == C_HALTGO)
        m_stall = (m_stall == 32'hFFFF_FFFF) ? m_stall : m_stall + 32'd1;
      if (c == C_BR)
        m_flush = (m_flush == 32'hFFFF_FFFF) ? m_flush : m_flush + 32'd1;
      if (c == C_HALTGO) begin
        m_mode = M_DRAIN; m_left = DC;
      end else if (m_mode == M_DRAIN) begin
        m_left--;
        if (m_left == 0) m_mode = M_HALTED;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_ctrl", {21'd0, ctrl}, {21'd0, vec(classify())});
      chk("model_stall_cnt", stall_cnt, exp_stall());
      chk("model_flush_cnt", flush_cnt, exp_flush());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b0; dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b0;
    halt_EX_MEM = 1'b0; branch_taken_EX = 1'b0; memread_ID_EX = 1'b0;
    Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
  endtask

  task automatic rand_inputs();
    ihit            = ($urandom_range(0, 3) != 0);
    dhit            = ($urandom_range(0, 4) < 3);
    dmemREN_EX_MEM  = ($urandom_range(0, 4) == 0);
    dmemWEN_EX_MEM  = ($urandom_range(0, 9) == 0);
    halt_EX_MEM     = ($urandom_range(0, 29) == 0);
    branch_taken_EX = ($urandom_range(0, 6) == 0);
    memread_ID_EX   = ($urandom_range(0, 2) == 0);
    Rt_ID_EX        = 5'($urandom_range(0, 3));
    Rs_IF_ID        = 5'($urandom_range(0, 3));
    Rt_IF_ID        = 5'($urandom_range(0, 3));
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    tick(); tick();
    #3;
    chk("reset_ctrl", {21'd0, ctrl}, {21'd0, V_RESET});
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    tick();
    RST = 1'b0;
    #3 chk("post_reset_normal", {21'd0, ctrl}, {21'd0, V_NORMAL});

    tick();
    memread_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5; Rt_IF_ID = 5'd3;
    #3 chk("load_use_rs", {21'd0, ctrl}, {21'd0, V_LU});
    tick();
    memread_ID_EX = 1'b0;
    #3 chk("load_use_one_cycle", {21'd0, ctrl}, {21'd0, V_NORMAL});
    tick();
    memread_ID_EX = 1'b1; Rt_ID_EX = 5'd7; Rs_IF_ID = 5'd1; Rt_IF_ID = 5'd7;
    #3 chk("load_use_rt", {21'd0, ctrl}, {21'd0, V_LU});
    tick();
    Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
    #3 chk("load_use_r0", {21'd0, ctrl}, {21'd0, V_NORMAL});
    tick();
    clear_inputs();

    dmemREN_EX_MEM = 1'b1; dhit = 1'b0; branch_taken_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3 chk("dmem_freeze", {21'd0, ctrl}, {21'd0, V_FREEZE});
      tick();
    end
    dhit = 1'b1;
    #3 chk("branch_on_dhit", {21'd0, ctrl}, {21'd0, V_BR});
    tick();
    clear_inputs();

    RST = 1'b1;
    tick();
    RST = 1'b0;
    ihit = 1'b0;
    repeat (4) tick();
    ihit = 1'b1; branch_taken_EX = 1'b1;
    repeat (2) tick();
    branch_taken_EX = 1'b0;
    #3;
`ifdef PIPE_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 32'd4);
    chk("perf_flush_cnt", flush_cnt, 32'd2);
`else
    chk("perf_stall_cnt_off", stall_cnt, 32'd0);
    chk("perf_flush_cnt_off", flush_cnt, 32'd0);
`endif
    tick();

    halt_EX_MEM = 1'b1;
    #3 chk("halt_accept", {21'd0, ctrl}, {21'd0, V_HALTGO});
    tick();
    rand_inputs();
    #3 chk("drain_1", {21'd0, ctrl}, {21'd0, V_DRAIN});
    tick();
    rand_inputs();
    #3 chk("drain_2", {21'd0, ctrl}, {21'd0, V_DRAIN});
    tick();
    rand_inputs();
    #3 chk("halted", {21'd0, ctrl}, {21'd0, V_HALTED});
    for (int i = 0; i < 5; i++) begin
      tick();
      rand_inputs();
      #3 chk("halt_sticky", {31'd0, halt}, 32'd1);
    end
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #3 chk("halt_cleared", {31'd0, halt}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      tick();
      rand_inputs();
      RST = ($urandom_range(0, 149) == 0) ||
            (m_mode == M_HALTED && $urandom_range(0, 5) == 0) ||
            (m_mode == M_DRAIN  && $urandom_range(0, 7) == 0);
    end
    tick();
    RST = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
